fifo_out_ctrl: RTL and testbench

FIFO_OUT_CTRL -- requirements
Module: fifo_out_ctrl

---
 rtl/fifo_out_ctrl.sv | 150 +++++++++++++++
 tb/tb_fifo_out_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_out_ctrl.sv
// fifo_out_ctrl: FIFO controller in front of an external 2**ADDR_W-entry register file.
// Optional macro FIFO_OUT_SIMUL_RW_EN: allow a push and a pop in the same cycle.
module fifo_out_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic              wr_ack,
  output logic              wr_err,
  output logic              rd_ack,
  output logic              rd_err,
  output logic [ADDR_W:0]   data_count,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_wAddr,
  output logic [ADDR_W-1:0] rf_rAddr,
  output logic [DATA_W-1:0] rf_wData,
  input  logic [DATA_W-1:0] rf_rData
);

  localparam int              DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {
    INIT,
    NO_OP,
    WRITE,
    WR_ERROR,
    READ,
    RD_ERROR
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   head_q, head_d;
  logic [ADDR_W-1:0]   tail_q, tail_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                do_wr, do_rd;

`ifdef FIFO_OUT_SIMUL_RW_EN
  // Read-side result of a simultaneous push/pop; the state register carries the write side.
  logic                rd_ack_x_q, rd_ack_x_d;
  logic                rd_err_x_q, rd_err_x_d;
`endif

  assign full       = (count_q == FULL_CNT);
  assign empty      = (count_q == '0);
  assign data_count = count_q;
  assign rf_wAddr   = tail_q;
  assign rf_rAddr   = head_q;
  assign rf_wData   = din;
  assign dout       = dout_q;

  // A push into a full FIFO is allowed only when a pop frees a slot at the same edge.
  always_comb begin
`ifdef FIFO_OUT_SIMUL_RW_EN
    do_rd = rd_en & ~empty;
`else
    do_rd = rd_en & ~wr_en & ~empty;
`endif
    do_wr = wr_en & (~full | do_rd);
    rf_we = do_wr & ~reset;
  end

  // NOTE: every signal assigned in an always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = NO_OP;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    dout_d  = dout_q;

    if (wr_en) begin
      state_d = do_wr ? WRITE : WR_ERROR;
    end else if (rd_en) begin
      state_d = do_rd ? READ : RD_ERROR;
    end

    if (do_wr) begin
      tail_d = tail_q + ADDR_W'(1);
    end
    if (do_rd) begin
      head_d = head_q + ADDR_W'(1);
      dout_d = rf_rData;
    end

    if (do_wr && !do_rd) begin
      count_d = count_q + (ADDR_W + 1)'(1);
    end else if (do_rd && !do_wr) begin
      count_d = count_q - (ADDR_W + 1)'(1);
    end
  end

`ifdef FIFO_OUT_SIMUL_RW_EN
  always_comb begin
    rd_ack_x_d = wr_en & rd_en & do_rd;
    rd_err_x_d = wr_en & rd_en & ~do_rd;
  end
`endif

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  // The register file lives outside this block; only the control state is reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      dout_q  <= dout_d;
    end
  end

`ifdef FIFO_OUT_SIMUL_RW_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ack_x_q <= 1'b0;
      rd_err_x_q <= 1'b0;
    end else begin
      rd_ack_x_q <= rd_ack_x_d;
      rd_err_x_q <= rd_err_x_d;
    end
  end
`endif

  // Handshakes decode only the state register, so they have no input-to-output path.
  assign wr_ack = (state_q == WRITE);
  assign wr_err = (state_q == WR_ERROR);
`ifdef FIFO_OUT_SIMUL_RW_EN
  assign rd_ack = (state_q == READ) | rd_ack_x_q;
  assign rd_err = (state_q == RD_ERROR) | rd_err_x_q;
`else
  assign rd_ack = (state_q == READ);
  assign rd_err = (state_q == RD_ERROR);
`endif

endmodule

// File: tb/tb_fifo_out_ctrl.sv
// Self-checking bench for fifo_out_ctrl: constant vector table, scoreboard-driven
// fill/drain/wrap sequences, simultaneous-request and mid-operation reset cases.
module tb_fifo_out_ctrl;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 32;
  localparam int NVEC   = 9;

  logic              clk = 1'b0;
  logic              reset;
  logic              wr_en;
  logic              rd_en;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              full;
  logic              empty;
  logic              wr_ack;
  logic              wr_err;
  logic              rd_ack;
  logic              rd_err;
  logic [ADDR_W:0]   data_count;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_wAddr;
  logic [ADDR_W-1:0] rf_rAddr;
  logic [DATA_W-1:0] rf_wData;
  logic [DATA_W-1:0] rf_rData;

  fifo_out_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .din        (din),
    .dout       (dout),
    .full       (full),
    .empty      (empty),
    .wr_ack     (wr_ack),
    .wr_err     (wr_err),
    .rd_ack     (rd_ack),
    .rd_err     (rd_err),
    .data_count (data_count),
    .rf_we      (rf_we),
    .rf_wAddr   (rf_wAddr),
    .rf_rAddr   (rf_rAddr),
    .rf_wData   (rf_wData),
    .rf_rData   (rf_rData)
  );

  always #5 clk = ~clk;

  // Register-file model the controller drives.
  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (rf_we) mem[rf_wAddr] <= rf_wData;
  end
  assign rf_rData = mem[rf_rAddr];

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [DATA_W-1:0] sb [$];
  int                m_count;
  logic [ADDR_W-1:0] m_head;
  logic [ADDR_W-1:0] m_tail;
  logic [DATA_W-1:0] m_dout;

  typedef struct {
    logic              w;
    logic              r;
    logic [DATA_W-1:0] d;
    logic              wa;
    logic              we;
    logic              ra;
    logic              re;
    int                cnt;
    logic [DATA_W-1:0] dout;
  } vec_t;

  vec_t vecs [NVEC];

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_op(input logic w, input logic r, input logic [DATA_W-1:0] d);
    logic rd_req, ra, re, wa, we_err;
`ifdef FIFO_OUT_SIMUL_RW_EN
    rd_req = r;
`else
    rd_req = r & ~w;
`endif
    ra     = rd_req && (m_count != 0);
    re     = rd_req && (m_count == 0);
    wa     = w && ((m_count != DEPTH) || ra);
    we_err = w && !wa;

    @(negedge clk);
    wr_en = w;
    rd_en = r;
    din   = d;
    #1;
    check_bit("rf_we", rf_we, wa);
    check_word("rf_wAddr", 32'(rf_wAddr), 32'(m_tail));
    check_word("rf_rAddr", 32'(rf_rAddr), 32'(m_head));
    if (w) check_word("rf_wData", rf_wData, d);
    if (wa) begin
      sb.push_back(d);
      m_tail = m_tail + 5'd1;
    end
    m_count = m_count + int'(wa) - int'(ra);

    @(posedge clk);
    #1;
    if (ra) begin
      m_dout = sb.pop_front();
      m_head = m_head + 5'd1;
    end
    check_bit("wr_ack", wr_ack, wa);
    check_bit("wr_err", wr_err, we_err);
    check_bit("rd_ack", rd_ack, ra);
    check_bit("rd_err", rd_err, re);
    check_word("dout", dout, m_dout);
    check_word("data_count", 32'(data_count), 32'(m_count));
    check_bit("full", full, m_count == DEPTH);
    check_bit("empty", empty, m_count == 0);
  endtask

  task automatic do_reset(input logic w);
    @(negedge clk);
    reset = 1'b1;
    wr_en = w;
    rd_en = 1'b0;
    din   = 32'hDEAD_BEEF;
    #1;
    check_bit("reset_rf_we", rf_we, 1'b0);
    @(posedge clk);
    #1;
    check_word("reset_count", 32'(data_count), 32'd0);
    check_bit("reset_empty", empty, 1'b1);
    check_bit("reset_full", full, 1'b0);
    check_word("reset_dout", dout, 32'd0);
    check_bit("reset_wr_ack", wr_ack, 1'b0);
    check_bit("reset_wr_err", wr_err, 1'b0);
    check_bit("reset_rd_ack", rd_ack, 1'b0);
    check_bit("reset_rd_err", rd_err, 1'b0);
    check_word("reset_wAddr", 32'(rf_wAddr), 32'd0);
    check_word("reset_rAddr", 32'(rf_rAddr), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    wr_en = 1'b0;
    sb.delete();
    m_count = 0;
    m_head  = '0;
    m_tail  = '0;
    m_dout  = '0;
    do_op(1'b0, 1'b0, '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b0, 1'b1, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 0, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 32'hA1, 1'b1, 1'b0, 1'b0, 1'b0, 1, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 32'hA2, 1'b1, 1'b0, 1'b0, 1'b0, 2, 32'h0};
    vecs[3] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 2, 32'h0};
    vecs[4] = '{1'b0, 1'b1, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 1, 32'hA1};
`ifdef FIFO_OUT_SIMUL_RW_EN
    vecs[5] = '{1'b1, 1'b1, 32'hA3, 1'b1, 1'b0, 1'b1, 1'b0, 1, 32'hA2};
    vecs[6] = '{1'b0, 1'b1, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 0, 32'hA3};
    vecs[7] = '{1'b0, 1'b1, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 0, 32'hA3};
`else
    vecs[5] = '{1'b1, 1'b1, 32'hA3, 1'b1, 1'b0, 1'b0, 1'b0, 2, 32'hA1};
    vecs[6] = '{1'b0, 1'b1, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 1, 32'hA2};
    vecs[7] = '{1'b0, 1'b1, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 0, 32'hA3};
`endif
    vecs[8] = '{1'b0, 1'b1, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 0, 32'hA3};

    reset = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = '0;

    // Constant vector table from an empty FIFO.
    do_reset(1'b0);
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      wr_en = vecs[i].w;
      rd_en = vecs[i].r;
      din   = vecs[i].d;
      @(posedge clk);
      #1;
      check_bit($sformatf("vec%0d_wr_ack", i), wr_ack, vecs[i].wa);
      check_bit($sformatf("vec%0d_wr_err", i), wr_err, vecs[i].we);
      check_bit($sformatf("vec%0d_rd_ack", i), rd_ack, vecs[i].ra);
      check_bit($sformatf("vec%0d_rd_err", i), rd_err, vecs[i].re);
      check_word($sformatf("vec%0d_count", i), 32'(data_count), 32'(vecs[i].cnt));
      check_word($sformatf("vec%0d_dout", i), dout, vecs[i].dout);
      check_bit($sformatf("vec%0d_empty", i), empty, vecs[i].cnt == 0);
    end

    // Fill to full, overflow, drain, underflow.
    do_reset(1'b0);
    for (int i = 0; i < DEPTH; i++) do_op(1'b1, 1'b0, 32'h100 + 32'(i));
    check_bit("fill_full", full, 1'b1);
    check_word("fill_count", 32'(data_count), 32'd32);
    check_word("fill_tail_wrap", 32'(rf_wAddr), 32'd0);
    do_op(1'b1, 1'b0, 32'hBAD);
    check_bit("overflow_wr_err", wr_err, 1'b1);
    check_word("overflow_count", 32'(data_count), 32'd32);
    do_op(1'b0, 1'b0, '0);
    for (int i = 0; i < DEPTH; i++) begin
      do_op(1'b0, 1'b1, '0);
      check_word($sformatf("drain%0d_dout", i), dout, 32'h100 + 32'(i));
    end
    check_bit("drain_empty", empty, 1'b1);
    do_op(1'b0, 1'b1, '0);
    check_bit("underflow_rd_err", rd_err, 1'b1);
    check_word("underflow_dout", dout, 32'h11F);

    // Pointer wrap across 31 -> 0.
    do_reset(1'b0);
    for (int i = 0; i < 20; i++) do_op(1'b1, 1'b0, 32'h200 + 32'(i));
    for (int i = 0; i < 20; i++) do_op(1'b0, 1'b1, '0);
    for (int i = 0; i < 20; i++) do_op(1'b1, 1'b0, 32'h300 + 32'(i));
    check_word("wrap_tail", 32'(rf_wAddr), 32'd8);
    for (int i = 0; i < 20; i++) begin
      do_op(1'b0, 1'b1, '0);
      check_word($sformatf("wrap%0d_dout", i), dout, 32'h300 + 32'(i));
    end

    // Simultaneous push and pop with five entries.
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) do_op(1'b1, 1'b0, 32'h400 + 32'(i));
    do_op(1'b1, 1'b1, 32'h4FF);
    check_bit("rw_wr_ack", wr_ack, 1'b1);
`ifdef FIFO_OUT_SIMUL_RW_EN
    check_word("rw_count", 32'(data_count), 32'd5);
    check_bit("rw_rd_ack", rd_ack, 1'b1);
`else
    check_word("rw_count", 32'(data_count), 32'd6);
    check_bit("rw_rd_ack", rd_ack, 1'b0);
`endif

    // Reset during a push with ten entries and a non-zero dout.
    do_reset(1'b0);
    for (int i = 0; i < 11; i++) do_op(1'b1, 1'b0, 32'h500 + 32'(i));
    do_op(1'b0, 1'b1, '0);
    check_word("pre_reset_count", 32'(data_count), 32'd10);
    do_reset(1'b1);

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      int op;
      op = int'($urandom_range(0, 3));
      do_op(op == 1 || op == 3, op == 2 || op == 3, $urandom);
    end

    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
